// File: rtl/addsub_accumulator_if.sv
// Command/result bus of the add/sub accumulator stage.
// The source drives commands and the consumer accepts results.
interface addsub_accumulator_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] acc;
  logic             c_out_q;
  logic             ovf_q;
  logic             ovf_sticky;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, acc, c_out_q,
    input  ovf_q, ovf_sticky, op_count
  );

  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, acc, c_out_q,
    output ovf_q, ovf_sticky, op_count
  );
endinterface

// File: rtl/addsub_accumulator.sv
// Accumulator stage around a 6-bit ripple adder/subtractor.
// One command per pass: IDLE accepts, EXEC updates, DONE presents.
module addsub_accumulator #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic reset_n,
  addsub_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LD  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] acc_q;
  logic             c_q;
  logic             v_q;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             sel;
  logic [WIDTH-1:0] y_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;
  logic             c_out;
  logic             overflow;

  assign sel   = (op_q == OP_SUB);
  assign y_eff = data_q ^ {WIDTH{sel}};
  assign c[0]  = sel;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    assign sum[i] = acc_q[i] ^ y_eff[i] ^ c[i];
    assign c[i+1] = (acc_q[i] & y_eff[i])
                  | (c[i] & (acc_q[i] ^ y_eff[i]));
  end

  assign c_out    = c[WIDTH];
  // Signed overflow: carry into MSB differs from carry out.
  assign overflow = c[WIDTH-1] ^ c[WIDTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_q        <= '0;
      data_q      <= '0;
      acc_q       <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            op_q       <= bus.in_op;
            data_q     <= bus.in_data;
            in_ready_q <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          unique case (op_q)
            OP_ADD, OP_SUB: begin
              acc_q    <= sum;
              c_q      <= c_out;
              v_q      <= overflow;
              sticky_q <= sticky_q | overflow;
              if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            OP_LD: begin
              acc_q    <= data_q;
              c_q      <= 1'b0;
              v_q      <= 1'b0;
              sticky_q <= 1'b0;
            end
            OP_CLR: begin
              acc_q    <= '0;
              c_q      <= 1'b0;
              v_q      <= 1'b0;
              sticky_q <= 1'b0;
              cnt_q    <= '0;
            end
            default: ;
          endcase
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.acc        = acc_q;
  assign bus.c_out_q    = c_q;
  assign bus.ovf_q      = v_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.op_count   = cnt_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Bench for addsub_accumulator: directed cases plus random
// commands scored against an integer-arithmetic model.
module tb_addsub_accumulator;

  localparam int WIDTH = 6;
  localparam int CNT_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LD  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic clk;
  logic reset_n;

  addsub_accumulator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  addsub_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int m_acc, m_c, m_v, m_sticky, m_cnt;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int to_s(input int u);
    return (u >= 32) ? u - 64 : u;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_c = 0; m_v = 0;
    m_sticky = 0; m_cnt = 0;
  endtask

  task automatic model_apply(input logic [1:0] op,
                             input logic [5:0] d);
    int a, b, r;
    a = m_acc;
    b = int'(d);
    case (op)
      OP_ADD: begin
        m_acc = (a + b) % 64;
        m_c   = (a + b > 63) ? 1 : 0;
        r     = to_s(a) + to_s(b);
      end
      OP_SUB: begin
        m_acc = (a - b + 64) % 64;
        m_c   = (a >= b) ? 1 : 0;
        r     = to_s(a) - to_s(b);
      end
      OP_LD: begin
        m_acc = b; m_c = 0; m_v = 0; m_sticky = 0;
      end
      default: begin
        m_acc = 0; m_c = 0; m_v = 0;
        m_sticky = 0; m_cnt = 0;
      end
    endcase
    if (op == OP_ADD || op == OP_SUB) begin
      m_v = (r > 31 || r < -32) ? 1 : 0;
      if (m_v == 1) m_sticky = 1;
      if (m_cnt < 15) m_cnt++;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_acc"}, 32'(bus.acc), m_acc);
    check({tag, "_c"}, 32'(bus.c_out_q), m_c);
    check({tag, "_v"}, 32'(bus.ovf_q), m_v);
    check({tag, "_stk"}, 32'(bus.ovf_sticky), m_sticky);
    check({tag, "_cnt"}, 32'(bus.op_count), m_cnt);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (bus.in_ready !== 1'b1)
      check("rdy_timeout", 32'(bus.in_ready), 1);
  endtask

  task automatic do_cmd(input logic [1:0] op,
                        input logic [5:0] d,
                        input int stall);
    wait_ready();
    bus.out_ready = (stall == 0);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_data   = d;
    tick();
    bus.in_valid = 1'b0;
    bus.in_op    = 2'($urandom);
    bus.in_data  = 6'($urandom);
    check("exec_ov", 32'(bus.out_valid), 0);
    check("exec_rdy", 32'(bus.in_ready), 0);
    tick();
    model_apply(op, d);
    check("lat_ov", 32'(bus.out_valid), 1);
    check_state("done");
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = ~i[0];
      bus.in_op    = OP_ADD;
      bus.in_data  = 6'd7;
      tick();
      bus.in_valid = 1'b0;
      check("hold_ov", 32'(bus.out_valid), 1);
      check("hold_rdy", 32'(bus.in_ready), 0);
      check_state("hold");
    end
    bus.out_ready = 1'b1;
    tick();
    check("rel_ov", 32'(bus.out_valid), 0);
    check("rel_rdy", 32'(bus.in_ready), 1);
    check_state("rel");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rop;
    int r;
    model_reset();
    reset_n       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op     = OP_LD;
    bus.in_data   = 6'd9;
    bus.out_ready = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rdy", 32'(bus.in_ready), 0);
      check("rst_ov", 32'(bus.out_valid), 0);
      check_state("rst");
    end
    bus.in_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    check("post_rdy", 32'(bus.in_ready), 1);
    check("post_ov", 32'(bus.out_valid), 0);

    do_cmd(OP_LD, 6'd5, 0);
    do_cmd(OP_ADD, 6'd3, 0);
    check("add3_acc", 32'(bus.acc), 8);
    check("add3_cnt", 32'(bus.op_count), 1);

    do_cmd(OP_LD, 6'd31, 0);
    do_cmd(OP_ADD, 6'd1, 0);
    check("ovf_acc", 32'(bus.acc), 32);
    check("ovf_v", 32'(bus.ovf_q), 1);
    check("ovf_stk", 32'(bus.ovf_sticky), 1);
    do_cmd(OP_SUB, 6'd1, 0);
    check("sub_acc", 32'(bus.acc), 31);
    check("sub_c", 32'(bus.c_out_q), 1);
    check("sub_v", 32'(bus.ovf_q), 1);
    do_cmd(OP_LD, 6'd0, 0);
    check("ld_stk", 32'(bus.ovf_sticky), 0);

    do_cmd(OP_SUB, 6'd1, 0);
    check("brw_acc", 32'(bus.acc), 63);
    check("brw_c", 32'(bus.c_out_q), 0);
    check("brw_v", 32'(bus.ovf_q), 0);
    do_cmd(OP_CLR, 6'd0, 0);
    check("clr_acc", 32'(bus.acc), 0);
    check("clr_cnt", 32'(bus.op_count), 0);

    do_cmd(OP_LD, 6'd10, 0);
    do_cmd(OP_ADD, 6'd7, 5);
    check("bp_acc", 32'(bus.acc), 17);

    do_cmd(OP_CLR, 6'd0, 0);
    do_cmd(OP_LD, 6'd0, 0);
    for (int i = 0; i < 17; i++) do_cmd(OP_ADD, 6'd1, 0);
    check("sat_cnt", 32'(bus.op_count), 15);
    check("sat_acc", 32'(bus.acc), 17);

    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_data  = 6'd1;
    tick();
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    model_reset();
    check("mid_ov", 32'(bus.out_valid), 0);
    check("mid_rdy", 32'(bus.in_ready), 0);
    check_state("mid");
    reset_n = 1'b1;
    tick();
    check("mid_rel_rdy", 32'(bus.in_ready), 1);
    check("mid_rel_ov", 32'(bus.out_valid), 0);
    check_state("mid_rel");

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      rop = OP_ADD;
      else if (r < 8) rop = OP_SUB;
      else if (r < 9) rop = OP_LD;
      else            rop = OP_CLR;
      do_cmd(rop, 6'($urandom), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
